// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU byte stores feed a small FIFO that is
// serialized LSB first on uart_tx, with a pollable status register.
module uart_tx_mmio #(
    parameter int unsigned ADDR_WIDTH = 32'd16,
    parameter int unsigned CLOCK_HZ   = 32'd27_000_000,
    parameter int unsigned BAUD       = 32'd115_200,
    parameter int unsigned DEPTH      = 32'd4,
    parameter int unsigned DATA_ADDR  = 32'h0000_0082,
    parameter int unsigned STAT_ADDR  = 32'h0000_0084
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr,
    input  logic                  byt,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data,
    output logic                  rd_sel,
    output logic                  uart_tx,
    output logic                  irq_empty
);
    localparam int unsigned DIV    = CLOCK_HZ / BAUD;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 32'd1;
    localparam int unsigned BAUD_W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;

    generate
        if (DIV < 32'd2) begin : g_bad_div
            $error("uart_tx_mmio: CLOCK_HZ/BAUD must be at least 2");
        end
        if ((DEPTH < 32'd2) || (DEPTH > 32'd16) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0)) begin : g_bad_depth
            $error("uart_tx_mmio: DEPTH must be a power of 2 in 2..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_r, state_next_s;
    logic [7:0]         mem_r [DEPTH];
    logic [PTR_W-1:0]   wptr_r, rptr_r;
    logic [CNT_W-1:0]   count_r, count_next_s;
    logic               overflow_r;
    logic [BAUD_W-1:0]  baud_r, baud_next_s;
    logic [2:0]         bit_idx_r, bit_idx_next_s;
    logic [7:0]         shift_r, shift_next_s;
    logic               tx_next_s;
    logic               pop_s, push_s, bit_end_s;
    logic               full_s, empty_s, idle_s, idle_next_s;
    logic               hit_data_s, hit_stat_s;
    logic [3:0]         count4_s;
    logic [15:0]        status_s;
    logic               unused_s;

    assign unused_s   = ^{byt, wr_data[15:8]};
    assign hit_data_s = (addr == ADDR_WIDTH'(DATA_ADDR));
    assign hit_stat_s = (addr == ADDR_WIDTH'(STAT_ADDR));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == CNT_W'(DEPTH));
    // Fullness is judged on the pre-pop count, so a write racing a pop while full is dropped.
    assign push_s     = wr && hit_data_s && !full_s;
    assign idle_s     = (state_r == IDLE) && empty_s;
    assign idle_next_s = (state_next_s == IDLE) && (count_next_s == {CNT_W{1'b0}});
    assign count4_s   = 4'(count_r);
    assign status_s   = {8'h00, count4_s, 1'b0, overflow_r, idle_s, full_s};
    assign bit_end_s  = (baud_r == BAUD_W'(DIV - 32'd1));

    // FIFO occupancy update from this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; entries are only read after being written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= wr_data[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1'b1);
            end
            count_r <= count_next_s;
            if (wr && hit_stat_s) begin
                overflow_r <= 1'b0;
            end else if (wr && hit_data_s && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Serializer next-state, pop decision and next line level
    always_comb begin
        state_next_s   = state_r;
        pop_s          = 1'b0;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        tx_next_s      = 1'b1;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = mem_r[rptr_r];
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    bit_idx_next_s = 3'd0;
                    state_next_s   = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = STOP;
                end else if (bit_end_s) begin
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_idx_next_s = bit_idx_r + 3'd1;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (bit_end_s && !empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = mem_r[rptr_r];
                    state_next_s = START;
                end else if (bit_end_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if ((state_r == IDLE) || bit_end_s) begin
            baud_next_s = {BAUD_W{1'b0}};
        end else begin
            baud_next_s = baud_r + BAUD_W'(1'b1);
        end
        case (state_next_s)
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = shift_next_s[0];
            default: tx_next_s = 1'b1;
        endcase
    end

    // Serializer state, bit timing and registered line/interrupt outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            uart_tx   <= 1'b1;
            irq_empty <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            baud_r    <= baud_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
            uart_tx   <= tx_next_s;
            irq_empty <= idle_next_s;
        end
    end

    // Bus read port: one-cycle latency, status snapshot taken before this edge's update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel  <= 1'b0;
            rd_data <= 16'h0000;
        end else begin
            rd_sel  <= hit_data_s || hit_stat_s;
            rd_data <= hit_stat_s ? status_s : 16'h0000;
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected read data and
// serial bytes; independent monitors decode rd_sel responses and uart_tx frames.
module tb_uart_tx_mmio;
    localparam int DIV = 10;
    localparam logic [15:0] A_DATA = 16'h0082;
    localparam logic [15:0] A_STAT = 16'h0084;
    localparam logic [15:0] A_NONE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic        wr;
    logic        byt;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_sel;
    logic        uart_tx;
    logic        irq_empty;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic        ser_abort;

    uart_tx_mmio #(
        .ADDR_WIDTH(16), .CLOCK_HZ(100_000), .BAUD(10_000), .DEPTH(4),
        .DATA_ADDR(32'h0000_0082), .STAT_ADDR(32'h0000_0084)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr(wr), .byt(byt),
        .wr_data(wr_data), .rd_data(rd_data), .rd_sel(rd_sel),
        .uart_tx(uart_tx), .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; a hit on either register queues the read data it must return.
    task automatic bus(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [15:0] rexp);
        addr = a;
        wr = w;
        wr_data = d;
        if (a == A_DATA || a == A_STAT) rd_q.push_back(rexp);
        tick();
        addr = A_NONE;
        wr = 1'b0;
        wr_data = 16'h0000;
    endtask

    task automatic send(input logic [7:0] b);
        tx_q.push_back(b);
        bus(A_DATA, 1'b1, {8'hA0, b}, 16'h0000);
    endtask

    task automatic ser_wait(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!rst_n) ser_abort = 1'b1;
        end
    endtask

    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (rd_sel) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_unexpected: got rd_sel=1 rd_data=0x%04h, expected no response", rd_data);
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
        end
    end

    initial begin : ser_mon
        logic [9:0] frame;
        forever begin
            @(negedge uart_tx);
            ser_abort = 1'b0;
            ser_wait(DIV / 2);
            frame[0] = uart_tx;
            for (int b = 1; b < 10; b++) begin
                ser_wait(DIV);
                frame[b] = uart_tx;
            end
            if (!ser_abort) begin
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_unexpected: got byte 0x%02h, expected no frame", frame[8:1]);
                end else begin
                    check("frame", {6'h00, frame}, {6'h00, 1'b1, tx_q.pop_front(), 1'b0});
                end
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [9:0] frame55;
        int errs;
        rst_n = 1'b0;
        addr = A_NONE;
        wr = 1'b0;
        byt = 1'b1;
        wr_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", {15'h0, uart_tx}, 16'h0001);
        check("rst_rd_sel", {15'h0, rd_sel}, 16'h0000);
        check("rst_rd_data", rd_data, 16'h0000);
        check("rst_irq_empty", {15'h0, irq_empty}, 16'h0001);
        rst_n = 1'b1;
        tick();

        // Status when empty, unmapped read, write to an unmapped address.
        bus(A_STAT, 1'b0, 16'hFFFF, 16'h0002);
        bus(16'h0100, 1'b0, 16'h0000, 16'h0000);
        check("miss_rd_sel", {15'h0, rd_sel}, 16'h0000);
        check("miss_rd_data", rd_data, 16'h0000);
        bus(16'h0086, 1'b1, 16'h00AB, 16'h0000);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0002);

        // Single byte 0x55: exact bit timing and irq_empty.
        frame55 = {1'b1, 8'h55, 1'b0};
        send(8'h55);
        check("tx_before_start", {15'h0, uart_tx}, 16'h0001);
        check("irq_busy", {15'h0, irq_empty}, 16'h0000);
        errs = 0;
        for (int k = 0; k < 10 * DIV; k++) begin
            tick();
            if (uart_tx !== frame55[k / DIV]) errs++;
        end
        check("frame55_bit_errors", 16'(errs), 16'h0000);
        check("irq_last_stop_cycle", {15'h0, irq_empty}, 16'h0000);
        tick();
        check("irq_after_frame", {15'h0, irq_empty}, 16'h0001);
        check("tx_idle_after_frame", {15'h0, uart_tx}, 16'h0001);
        repeat (5) tick();

        // Three back-to-back bytes: no idle gap, status count 2,1,0.
        send(8'h41);
        send(8'h42);
        send(8'h43);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0020);
        repeat (97) tick();
        check("stop_bit_frame1", {15'h0, uart_tx}, 16'h0001);
        tick();
        check("no_gap_start2", {15'h0, uart_tx}, 16'h0000);
        repeat (3) tick();
        bus(A_STAT, 1'b0, 16'h0000, 16'h0010);
        repeat (99) tick();
        bus(A_STAT, 1'b0, 16'h0000, 16'h0000);
        repeat (100) tick();

        // Overflow: six writes into a depth-4 FIFO, then a write colliding with a pop while full.
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h66);
        bus(A_DATA, 1'b1, 16'h00EE, 16'h0000);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0045);
        bus(A_STAT, 1'b1, 16'h1234, 16'h0045);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0041);
        repeat (92) tick();
        bus(A_DATA, 1'b1, 16'h00EF, 16'h0000);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0034);
        bus(A_STAT, 1'b1, 16'h0000, 16'h0034);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0030);
        repeat (420) tick();
        bus(A_STAT, 1'b0, 16'h0000, 16'h0002);

        // Push and pop on the same edge at the end of a stop bit with count=1.
        send(8'h5A);
        send(8'hC3);
        repeat (99) tick();
        send(8'h3C);
        bus(A_STAT, 1'b0, 16'h0000, 16'h0010);
        repeat (310) tick();

        // Asynchronous reset in the middle of a low data bit.
        send(8'h00);
        repeat (24) tick();
        check("tx_low_before_rst", {15'h0, uart_tx}, 16'h0000);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", {15'h0, uart_tx}, 16'h0001);
        check("rst_async_irq", {15'h0, irq_empty}, 16'h0001);
        tx_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        bus(A_STAT, 1'b0, 16'h0000, 16'h0002);
        repeat (80) tick();
        send(8'hA5);
        repeat (110) tick();

        check("frames_outstanding", 16'(tx_q.size()), 16'h0000);
        check("reads_outstanding", 16'(rd_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
